// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared op/condition encodings and CC reset value for the pipelined Y86 ALU
package alu_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_OR  = 3'b100,
        OP_SHL = 3'b101,
        OP_SAR = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_LE     = 3'd1,
        COND_L      = 3'd2,
        COND_E      = 3'd3,
        COND_NE     = 3'd4,
        COND_GE     = 3'd5,
        COND_G      = 3'd6,
        COND_RSVD   = 3'd7
    } cond_fn_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU datapath and flags; ALU_EXT_OPS_EN enables OR and the shifts
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             err
);

    logic [WIDTH-1:0] raw;

`ifdef ALU_EXT_OPS_EN
    localparam int SHW = $clog2(WIDTH);
    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];
`endif

    always_comb begin
        raw = '0;
        err = 1'b0;
        case (op)
            OP_ADD: raw = a + b;
            OP_SUB: raw = a - b;
            OP_AND: raw = a & b;
            OP_XOR: raw = a ^ b;
`ifdef ALU_EXT_OPS_EN
            OP_OR:  raw = a | b;
            OP_SHL: raw = a << shamt;
            OP_SAR: raw = $signed(a) >>> shamt;
            OP_SHR: raw = a >> shamt;
`else
            default: err = 1'b1;
`endif
        endcase
    end

    // Unsupported ops report all-zero flags, including zf despite the zero result.
    assign result = raw;
    assign zf     = !err && (raw == '0);
    assign sf     = raw[WIDTH-1];
    assign of     = (op == OP_ADD) ? ((a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1])) :
                    (op == OP_SUB) ? ((a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1])) :
                                     1'b0;

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - pipelined Y86 execute ALU with valid/ready handshake, CC register and branch condition
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zf,
    output logic             out_sf,
    output logic             out_of,
    output logic             out_err,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    input  logic [2:0]       cond_fn,
    output logic             cnd
);

    logic             stall;
    logic             advance;
    logic             core_valid;
    logic             core_set_cc;
    alu_op_e          core_op;
    logic [WIDTH-1:0] core_a;
    logic [WIDTH-1:0] core_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zf;
    logic             alu_sf;
    logic             alu_of;
    logic             alu_err;
    logic             ret_set_cc;
    cc_t              cc;

    // The whole pipe freezes while the output holds an unaccepted result.
    assign stall    = out_valid && !out_ready;
    assign advance  = !stall;
    assign in_ready = advance;

    generate
        if (STAGES == 2) begin : g_two
            logic             s1_valid;
            logic             s1_set_cc;
            alu_op_e          s1_op;
            logic [WIDTH-1:0] s1_a;
            logic [WIDTH-1:0] s1_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s1_valid  <= 1'b0;
                    s1_set_cc <= 1'b0;
                    s1_op     <= OP_ADD;
                    s1_a      <= '0;
                    s1_b      <= '0;
                end else if (advance) begin
                    s1_valid <= in_valid;
                    if (in_valid) begin
                        s1_set_cc <= in_set_cc;
                        s1_op     <= alu_op_e'(in_op);
                        s1_a      <= in_a;
                        s1_b      <= in_b;
                    end
                end
            end

            assign core_valid  = s1_valid;
            assign core_set_cc = s1_set_cc;
            assign core_op     = s1_op;
            assign core_a      = s1_a;
            assign core_b      = s1_b;
        end else begin : g_one
            assign core_valid  = in_valid;
            assign core_set_cc = in_set_cc;
            assign core_op     = alu_op_e'(in_op);
            assign core_a      = in_a;
            assign core_b      = in_b;
        end
    endgenerate

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op     (core_op),
        .a      (core_a),
        .b      (core_b),
        .result (alu_result),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of),
        .err    (alu_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zf     <= 1'b0;
            out_sf     <= 1'b0;
            out_of     <= 1'b0;
            out_err    <= 1'b0;
            ret_set_cc <= 1'b0;
            cc         <= CC_RESET;
        end else begin
            if (out_valid && out_ready && ret_set_cc && !out_err) begin
                cc <= '{zf: out_zf, sf: out_sf, of: out_of};
            end
            if (advance) begin
                out_valid <= core_valid;
                if (core_valid) begin
                    out_result <= alu_result;
                    out_zf     <= alu_zf;
                    out_sf     <= alu_sf;
                    out_of     <= alu_of;
                    out_err    <= alu_err;
                    ret_set_cc <= core_set_cc;
                end
            end
        end
    end

    assign cc_zf = cc.zf;
    assign cc_sf = cc.sf;
    assign cc_of = cc.of;

    always_comb begin
        cnd = 1'b0;
        case (cond_fn_e'(cond_fn))
            COND_ALWAYS: cnd = 1'b1;
            COND_LE:     cnd = (cc.sf ^ cc.of) | cc.zf;
            COND_L:      cnd = cc.sf ^ cc.of;
            COND_E:      cnd = cc.zf;
            COND_NE:     cnd = !cc.zf;
            COND_GE:     cnd = !(cc.sf ^ cc.of);
            COND_G:      cnd = !(cc.sf ^ cc.of) && !cc.zf;
            COND_RSVD:   cnd = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - scoreboard bench driving alu_pipe at STAGES=1 and STAGES=2 side by side
module tb_alu_pipe;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [2:0]   in_op;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_set_cc;
    logic         out_ready;
    logic [2:0]   cond_fn;

    logic         d1_in_ready, d1_out_valid, d1_zf, d1_sf, d1_of, d1_err;
    logic         d1_cc_zf, d1_cc_sf, d1_cc_of, d1_cnd;
    logic [W-1:0] d1_result;
    logic         d2_in_ready, d2_out_valid, d2_zf, d2_sf, d2_of, d2_err;
    logic         d2_cc_zf, d2_cc_sf, d2_cc_of, d2_cnd;
    logic [W-1:0] d2_result;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W), .STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d1_in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc), .out_valid(d1_out_valid),
        .out_ready(out_ready), .out_result(d1_result), .out_zf(d1_zf), .out_sf(d1_sf),
        .out_of(d1_of), .out_err(d1_err), .cc_zf(d1_cc_zf), .cc_sf(d1_cc_sf), .cc_of(d1_cc_of),
        .cond_fn(cond_fn), .cnd(d1_cnd)
    );

    alu_pipe #(.WIDTH(W), .STAGES(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(d2_in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_set_cc(in_set_cc), .out_valid(d2_out_valid),
        .out_ready(out_ready), .out_result(d2_result), .out_zf(d2_zf), .out_sf(d2_sf),
        .out_of(d2_of), .out_err(d2_err), .cc_zf(d2_cc_zf), .cc_sf(d2_cc_sf), .cc_of(d2_cc_of),
        .cond_fn(cond_fn), .cnd(d2_cnd)
    );

    typedef struct {
        logic [W-1:0] result;
        logic         zf;
        logic         sf;
        logic         of;
        logic         err;
        logic         set_cc;
        int           acc_edge;
        int           acc_stalls;
    } beat_t;

    beat_t      q0[$];
    beat_t      q1[$];
    logic [2:0] mcc [2];
    int         stalls [2];
    int         accepted [2];
    int         retired [2];
    int         edge_no;
    int         errors;
    int         checks;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic beat_t model(input logic [2:0] op, input logic [W-1:0] a,
                                    input logic [W-1:0] b, input logic sc);
        beat_t             m;
        logic signed [W:0] wide;
        int                sh;
        sh = int'(b & 64'd63);
        m.result = '0;
        m.zf = 1'b0;
        m.sf = 1'b0;
        m.of = 1'b0;
        m.err = 1'b0;
        m.set_cc = sc;
        m.acc_edge = 0;
        m.acc_stalls = 0;
        wide = '0;
        case (op)
            3'd0: begin
                wide = $signed({a[W-1], a}) + $signed({b[W-1], b});
                m.result = wide[W-1:0];
                m.of = (wide[W] != wide[W-1]);
            end
            3'd1: begin
                wide = $signed({a[W-1], a}) - $signed({b[W-1], b});
                m.result = wide[W-1:0];
                m.of = (wide[W] != wide[W-1]);
            end
            3'd2: m.result = a & b;
            3'd3: m.result = a ^ b;
            default: begin
`ifdef ALU_EXT_OPS_EN
                case (op)
                    3'd4:    m.result = a | b;
                    3'd5:    m.result = a << sh;
                    3'd6:    m.result = W'($signed(a) >>> sh);
                    default: m.result = a >> sh;
                endcase
`else
                m.err = 1'b1;
`endif
            end
        endcase
        if (!m.err) begin
            m.zf = (m.result == '0);
            m.sf = m.result[W-1];
        end
        return m;
    endfunction

    // cc packed as {zf, sf, of}
    function automatic logic cond_model(input logic [2:0] cc, input logic [2:0] fn);
        logic zf, sf, of;
        {zf, sf, of} = cc;
        case (fn)
            3'd0:    return 1'b1;
            3'd1:    return (sf != of) || zf;
            3'd2:    return sf != of;
            3'd3:    return zf;
            3'd4:    return !zf;
            3'd5:    return sf == of;
            3'd6:    return (sf == of) && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [W-1:0] rnd64();
        case ($urandom_range(0, 3))
            0:       return 64'h7FFF_FFFF_FFFF_FFFF;
            1:       return 64'h8000_0000_0000_0000;
            2:       return W'($urandom_range(0, 15));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic sb(input int d, input int s, input logic irdy, input logic ov,
                      input logic [W-1:0] res, input logic zf, input logic sf, input logic of,
                      input logic err, input logic [2:0] cc, input logic cnd_o);
        beat_t b;
        string p;
        int    depth;
        p = (d == 0) ? "s1" : "s2";
        depth = (d == 0) ? q0.size() : q1.size();
        chk({p, "_cc"}, W'(cc), W'(mcc[d]));
        chkb({p, "_cnd"}, cnd_o, cond_model(mcc[d], cond_fn));
        chkb({p, "_in_ready"}, irdy, !(ov && !out_ready));
        if (ov && out_ready) begin
            checks++;
            assert (depth > 0) else begin
                errors++;
                $error("FAIL %s_spurious_retire observed=valid expected=empty_pipe", p);
            end
            if (depth > 0) begin
                b = (d == 0) ? q0.pop_front() : q1.pop_front();
                chk({p, "_result"}, res, b.result);
                chkb({p, "_zf"}, zf, b.zf);
                chkb({p, "_sf"}, sf, b.sf);
                chkb({p, "_of"}, of, b.of);
                chkb({p, "_err"}, err, b.err);
                chk({p, "_latency"}, W'(edge_no - b.acc_edge), W'(s + stalls[d] - b.acc_stalls));
                if (b.set_cc && !b.err) mcc[d] = {b.zf, b.sf, b.of};
                retired[d]++;
            end
        end
        if (in_valid && irdy) begin
            b = model(in_op, in_a, in_b, in_set_cc);
            b.acc_edge = edge_no;
            b.acc_stalls = stalls[d];
            if (d == 0) q0.push_back(b);
            else q1.push_back(b);
            accepted[d]++;
        end
        if (ov && !out_ready) stalls[d]++;
    endtask

    task automatic tick();
        logic         hold1, hold2;
        logic [W-1:0] r1, r2;
        #1;
        hold1 = 1'b0;
        hold2 = 1'b0;
        r1 = d1_result;
        r2 = d2_result;
        if (rst) begin
            q0.delete();
            q1.delete();
            mcc[0] = 3'b100;
            mcc[1] = 3'b100;
            accepted[0] = 0;
            accepted[1] = 0;
            retired[0] = 0;
            retired[1] = 0;
        end else begin
            hold1 = d1_out_valid && !out_ready;
            hold2 = d2_out_valid && !out_ready;
            sb(0, 1, d1_in_ready, d1_out_valid, d1_result, d1_zf, d1_sf, d1_of, d1_err,
               {d1_cc_zf, d1_cc_sf, d1_cc_of}, d1_cnd);
            sb(1, 2, d2_in_ready, d2_out_valid, d2_result, d2_zf, d2_sf, d2_of, d2_err,
               {d2_cc_zf, d2_cc_sf, d2_cc_of}, d2_cnd);
        end
        @(posedge clk);
        edge_no++;
        @(negedge clk);
        if (hold1) begin
            chkb("s1_hold_valid", d1_out_valid, 1'b1);
            chk("s1_hold_result", d1_result, r1);
        end
        if (hold2) begin
            chkb("s2_hold_valid", d2_out_valid, 1'b1);
            chk("s2_hold_result", d2_result, r2);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic sc);
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_set_cc = sc;
    endtask

    task automatic idle(input int n);
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        edge_no = 0;
        stalls[0] = 0;
        stalls[1] = 0;
        rst = 1'b1;
        out_ready = 1'b1;
        cond_fn = 3'd0;
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        chkb("rst_s1_out_valid", d1_out_valid, 1'b0);
        chkb("rst_s2_out_valid", d2_out_valid, 1'b0);
        chk("rst_s1_result", d1_result, '0);
        chk("rst_s2_result", d2_result, '0);
        chk("rst_s1_flags", W'({d1_zf, d1_sf, d1_of, d1_err}), '0);
        chk("rst_s2_flags", W'({d2_zf, d2_sf, d2_of, d2_err}), '0);
        chk("rst_s1_cc", W'({d1_cc_zf, d1_cc_sf, d1_cc_of}), W'(3'b100));
        chk("rst_s2_cc", W'({d2_cc_zf, d2_cc_sf, d2_cc_of}), W'(3'b100));
        chkb("rst_s1_in_ready", d1_in_ready, 1'b1);
        chkb("rst_s2_in_ready", d2_in_ready, 1'b1);

        // Signed overflow on ADD, then L must be false since sf and of are both set.
        drive(1'b1, 3'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b1);
        tick();
        chk("add_ovf_result", d1_result, 64'h8000_0000_0000_0000);
        chk("add_ovf_flags", W'({d1_zf, d1_sf, d1_of}), W'(3'b011));
        idle(4);
        chk("add_ovf_s1_cc", W'({d1_cc_zf, d1_cc_sf, d1_cc_of}), W'(3'b011));
        chk("add_ovf_s2_cc", W'({d2_cc_zf, d2_cc_sf, d2_cc_of}), W'(3'b011));
        cond_fn = 3'd2;
        #1;
        chkb("cond_l_s1", d1_cnd, 1'b0);
        chkb("cond_l_s2", d2_cnd, 1'b0);

        drive(1'b1, 3'd1, 64'd5, 64'd5, 1'b1);
        tick();
        drive(1'b1, 3'd2, 64'hF0, 64'h0F, 1'b0);
        tick();
        idle(4);
        chk("sub_and_s1_cc", W'({d1_cc_zf, d1_cc_sf, d1_cc_of}), W'(3'b100));
        chk("sub_and_s2_cc", W'({d2_cc_zf, d2_cc_sf, d2_cc_of}), W'(3'b100));
        cond_fn = 3'd3;
        #1;
        chkb("cond_e_s1", d1_cnd, 1'b1);
        chkb("cond_e_s2", d2_cnd, 1'b1);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 3'd0, rnd64(), rnd64(), 1'($urandom_range(0, 1)));
            tick();
        end
        idle(4);

        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), rnd64(), rnd64(), 1'b1);
            tick();
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'($urandom_range(0, 7)), rnd64(), rnd64(), 1'b1);
            #1;
            chkb("stall_s1_in_ready", d1_in_ready, 1'b0);
            chkb("stall_s2_in_ready", d2_in_ready, 1'b0);
            tick();
        end
        out_ready = 1'b1;
        idle(5);
        chk("stall_s1_no_loss", W'(retired[0]), W'(accepted[0]));
        chk("stall_s2_no_loss", W'(retired[1]), W'(accepted[1]));

        for (int i = 0; i < 120; i++) begin
            cond_fn = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 3) != 0);
            drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), rnd64(), rnd64(),
                  1'($urandom_range(0, 1)));
            tick();
        end
        out_ready = 1'b1;
        idle(6);
        chk("rand_s1_no_loss", W'(retired[0]), W'(accepted[0]));
        chk("rand_s2_no_loss", W'(retired[1]), W'(accepted[1]));

        drive(1'b1, 3'd0, 64'd1, 64'd2, 1'b1);
        tick();
        drive(1'b1, 3'd1, 64'd9, 64'd3, 1'b1);
        tick();
        rst = 1'b1;
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chkb("midrst_s1_out_valid", d1_out_valid, 1'b0);
        chkb("midrst_s2_out_valid", d2_out_valid, 1'b0);
        chk("midrst_s2_cc", W'({d2_cc_zf, d2_cc_sf, d2_cc_of}), W'(3'b100));
        chkb("midrst_s1_in_ready", d1_in_ready, 1'b1);
        chkb("midrst_s2_in_ready", d2_in_ready, 1'b1);
        idle(3);

        // Only the low six bits of b count as the shift amount.
        drive(1'b1, 3'd5, 64'd1, 64'h43, 1'b1);
        tick();
`ifdef ALU_EXT_OPS_EN
        chk("shl_result", d1_result, 64'h8);
        chkb("shl_err", d1_err, 1'b0);
`else
        chk("shl_result", d1_result, '0);
        chkb("shl_err", d1_err, 1'b1);
`endif
        idle(4);
`ifdef ALU_EXT_OPS_EN
        chk("shl_s2_cc", W'({d2_cc_zf, d2_cc_sf, d2_cc_of}), W'(3'b000));
`else
        chk("shl_s2_cc", W'({d2_cc_zf, d2_cc_sf, d2_cc_of}), W'(3'b100));
`endif
        chk("end_s1_drained", W'(retired[0]), W'(accepted[0]));
        chk("end_s2_drained", W'(retired[1]), W'(accepted[1]));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
